// File: rtl/tri0_bus_arbiter.sv
// tri0_bus_arbiter: round-robin arbitrated shared bus that reads 0 when no driver owns it
module tri0_bus_arbiter #(
   parameter int N_DRV = 4,
   parameter int DATA_W = 8,
   parameter int MAX_HOLD = 4,
   localparam int ID_W = N_DRV > 1 ? $clog2(N_DRV) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_DRV-1:0]        req,
   input  logic [N_DRV*DATA_W-1:0] drv_data,
   output logic [N_DRV-1:0]        gnt,
   output logic [DATA_W-1:0]       bus,
   output logic                    bus_valid,
   output logic [ID_W-1:0]         owner,
   output logic                    contention
);
   localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] LIM = HW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
   localparam logic [0:0] IDLE = 1'b0, OWNED = 1'b1;

   logic [0:0] state, n_state;
   logic [ID_W-1:0] rr_ptr, n_rr, n_owner;
   logic [HW-1:0] hold_cnt, n_hold;
   logic [N_DRV-1:0] others;
   logic [DATA_W-1:0] sel;
   logic owner_req, lim;

   // first set bit of r at or after index s, wrapping
   function automatic logic [ID_W-1:0] pick(input logic [N_DRV-1:0] r, input int s);
      pick = '0;
      for (int i = N_DRV - 1; i >= 0; i--)
         if (r[(s + i) % N_DRV]) pick = ID_W'((s + i) % N_DRV);
   endfunction

   always_comb begin
      others = req & ~gnt;
      owner_req = |(req & gnt);
      lim = MAX_HOLD != 0 && hold_cnt == LIM;
      n_state = state;
      n_owner = owner;
      n_hold = hold_cnt;
      n_rr = rr_ptr;
      if (state == IDLE) begin
         if (|req) begin
            n_owner = pick(req, int'(rr_ptr) + 1);
            n_rr = n_owner;
            n_hold = '0;
            n_state = OWNED;
         end
      end else if (owner_req && !lim) begin
         n_hold = |others ? hold_cnt + 1'b1 : hold_cnt;
      end else if (|others) begin
         n_owner = pick(others, int'(owner) + 1);
         n_rr = n_owner;
         n_hold = '0;
      end else if (owner_req) begin
         n_hold = '0;
      end else begin
         n_state = IDLE;
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < N_DRV; i++)
         if (owner == ID_W'(i)) sel = drv_data[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         gnt <= '0;
         owner <= '0;
         rr_ptr <= ID_W'(N_DRV - 1);
         hold_cnt <= '0;
         bus <= '0;
         bus_valid <= 1'b0;
         contention <= 1'b0;
      end else begin
         state <= n_state;
         gnt <= n_state == OWNED ? {{(N_DRV-1){1'b0}}, 1'b1} << n_owner : '0;
         owner <= n_owner;
         rr_ptr <= n_rr;
         hold_cnt <= n_hold;
         bus <= |gnt ? sel : '0;
         bus_valid <= |gnt;
         contention <= $countones(req) > 1;
      end
endmodule

// File: tb/tb_tri0_bus_arbiter.sv
// tb_tri0_bus_arbiter: directed checks of grant, bus, round robin, handover and async reset
module tb_tri0_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] req;
   logic [31:0] drv_data = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
   logic [3:0] gnt;
   logic [7:0] bus;
   logic bus_valid;
   logic [1:0] owner;
   logic contention;
   int passed = 0, total = 0;
   int exp_own;

   tri0_bus_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req), .drv_data(drv_data), .gnt(gnt),
      .bus(bus), .bus_valid(bus_valid), .owner(owner), .contention(contention)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      req = 4'b1111;
      step;
      step;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_bus", 32'(bus), 32'h0);
      chk("rst_valid", 32'(bus_valid), 32'h0);
      chk("rst_cont", 32'(contention), 32'h0);
      rst_n = 1'b1;
      step;
      chk("rel_gnt", 32'(gnt), 32'h1);
      chk("rel_owner", 32'(owner), 32'h0);
      chk("rel_valid", 32'(bus_valid), 32'h0);
      chk("rel_cont", 32'(contention), 32'h1);
      step;
      chk("rel_bus", 32'(bus), 32'hC0);
      chk("rel_valid1", 32'(bus_valid), 32'h1);
      req = 4'b0000;
      step;
      chk("drop_gnt", 32'(gnt), 32'h0);
      chk("drop_bus", 32'(bus), 32'hC0);
      step;
      chk("idle_bus", 32'(bus), 32'h0);
      chk("idle_valid", 32'(bus_valid), 32'h0);
      req = 4'b0100;
      step;
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_owner", 32'(owner), 32'h2);
      chk("single_valid0", 32'(bus_valid), 32'h0);
      step;
      chk("single_bus", 32'(bus), 32'hA5);
      chk("single_valid", 32'(bus_valid), 32'h1);
      req = 4'b0000;
      step;
      chk("single_drop", 32'(gnt), 32'h0);
      step;
      chk("single_bus0", 32'(bus), 32'h0);
      chk("single_valid_off", 32'(bus_valid), 32'h0);

      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         step;
         exp_own = (i / 4) % 4;
         chk("rr_owner", 32'(owner), 32'(exp_own));
         chk("rr_gnt", 32'(gnt), 32'(1) << exp_own);
         chk("rr_cont", 32'(contention), 32'h1);
      end

      req = 4'b1010;
      step;
      chk("ho_first", 32'(gnt), 32'h2);
      step;
      chk("ho_hold", 32'(gnt), 32'h2);
      chk("ho_bus1", 32'(bus), 32'hB1);
      req = 4'b1000;
      step;
      chk("ho_gnt", 32'(gnt), 32'h8);
      chk("ho_noidle", 32'(bus_valid), 32'h1);
      chk("ho_bus_old", 32'(bus), 32'hB1);
      step;
      chk("ho_bus3", 32'(bus), 32'hD3);

      req = 4'b0001;
      step;
      chk("sole_gnt0", 32'(gnt), 32'h1);
      for (int i = 0; i < 20; i++) begin
         step;
         chk("sole_gnt", 32'(gnt), 32'h1);
         chk("sole_valid", 32'(bus_valid), 32'h1);
         chk("sole_cont", 32'(contention), 32'h0);
      end
      chk("sole_bus", 32'(bus), 32'hC0);

      req = 4'b0100;
      step;
      chk("ar_gnt", 32'(gnt), 32'h4);
      step;
      chk("ar_bus", 32'(bus), 32'hA5);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_gnt0", 32'(gnt), 32'h0);
      chk("ar_bus0", 32'(bus), 32'h0);
      chk("ar_valid0", 32'(bus_valid), 32'h0);
      chk("ar_owner0", 32'(owner), 32'h0);
      step;
      rst_n = 1'b1;
      req = 4'b1111;
      step;
      chk("ar_restart", 32'(gnt), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
